vin_ws2812_rx: RTL
==================

# vin_ws2812_rx

WS2812 one-wire stream decoder: samples an NRZ pulse-width-coded WS2812 data line, slices high-time into bits, and assembles 24-bit GRB pixel words. It captures the word for one selected pixel position per frame and reports the pixel count of each completed frame. It is the input-side counterpart of the WS2812 output plugin: an input plugin for loop-back testing and for sniffing external LED chains, with `value` mapped to a 32-bit input register.

## Interface

Parameters:
- CLK_MHZ, 27, system clock frequency in MHz; all pulse thresholds derive from it.
- LED_INDEX, 0, pixel position (0..255) within a frame whose GRB word is captured.

Ports:
- clk  input  1  system clock; one clock domain only.
- rst_n  input  1  reset, asynchronous assert, active-low; all state and outputs clear.
- din  input  1  raw WS2812 data line, asynchronous to clk.
- value  output  32  [23:0] last captured GRB word; [31:24] pixel count of the last completed frame, saturating at 255.
- valid  output  1  one-cycle pulse when value[23:0] updates.
- frame_done  output  1  one-cycle pulse when a reset gap ends a frame and value[31:24] updates.
- error  output  1  sticky; set on a malformed pulse; cleared only by rst_n or the next frame_done.

## Operation

- din passes through a 2-FF synchronizer. Edge detection runs on the synchronized signal.
- Derived cycle constants, using integer truncation:
  - T_MIN = CLK_MHZ*150/1000. At 27 MHz this is 4.
  - T_THR = CLK_MHZ*600/1000. At 27 MHz this is 16.
  - T_HMAX = CLK_MHZ*5. At 27 MHz this is 135.
  - T_RST = CLK_MHZ*50. At 27 MHz this is 1350.
- Counters:
  - 16-bit cycle counter.
  - 5-bit bit counter.
  - 8-bit pixel counter, saturating at 255.
  - 24-bit shift register, MSB first.
- FSM states: WAIT_GAP, IDLE, HIGH, LOW.
  - WAIT_GAP (reset state): count low cycles. On reaching T_RST, go to IDLE. Any high restarts the count.
  - IDLE: on a rising edge, clear the bit and pixel counters, then go to HIGH.
  - HIGH: count cycles while din is high.
    - On the falling edge, classify the pulse by its high-time h.
    - If h < T_MIN, the pulse is a glitch: set error, return to LOW, shift nothing.
    - Otherwise shift in (h >= T_THR), then go to LOW.
    - If h reaches T_HMAX, set error and go to WAIT_GAP.
  - LOW: count cycles while din is low.
    - A rising edge returns to HIGH.
    - If the low time reaches T_RST, the frame ends: value[31:24] <= pixel count, pulse frame_done, clear error, go to IDLE.
- On the 24th bit of a pixel:
  - If pixel count == LED_INDEX, load value[23:0] from the completed word and pulse valid.
  - The pixel counter then increments, saturating at 255. The bit counter wraps to 0.
- A partial pixel (fewer than 24 bits) at frame end is discarded and not counted.
- An error in HIGH aborts the frame: no frame_done is generated and value[31:24] is left unchanged.

## Timing

- Reset value of every output: value = 0, valid = 0, frame_done = 0, error = 0. The FSM resets to WAIT_GAP, so a frame already in flight when reset releases is ignored.
- Latency from the din falling edge of the 24th bit to the valid pulse: 2 sync cycles + 1 edge-detect cycle + 1 register cycle = 4 clk.
- Latency from the final din falling edge to frame_done: T_RST + 4 clk.
- If valid and frame_done would coincide, valid is emitted first. frame_done follows at least T_RST later by construction.
- Threshold boundary: h == T_THR decodes as 1; h == T_THR-1 decodes as 0.
- Deasserting rst_n mid-frame: outputs clear immediately, asynchronously. Decoding resumes only after a full reset gap.

## Structure

- Shared package `ws2812_pkg` holds:
  - the timing constants in ns (150/600/5000/50000);
  - the helper function converting ns to cycles;
  - the FSM state encoding.
  The package is shared with the transmitter so that both use one source of timing.
- Sub-module `ws2812_rx_phy` contains the synchronizer, edge detector and high-time slicer. Its outputs are bit_stb, bit_val, glitch, overlong and gap. The top level keeps the counters, capture logic and outputs.

## Test plan

All scenarios use CLK_MHZ = 27. A "1" bit is 22 cycles high then 12 low; a "0" bit is 11 cycles high then 23 low.

1. Reset, then 1500 low cycles, then one pixel 0xA5C33C, then 1500 low. Required: valid 4 clk after the 24th falling edge; value = 0x01A5C33C; exactly one frame_done.
2. LED_INDEX = 2, three pixels 0x111111, 0x222222, 0x333333, then a gap. Required: exactly one valid pulse, giving value[23:0] = 0x333333; value[31:24] = 3.
3. Threshold sweep with high-times of 15, 16 and 17 cycles. Required: the bits decode as 0, 1, 1 respectively.
4. A 3-cycle high glitch inside a frame. Required: error = 1, no bit shifted. The next frame's frame_done clears error.
5. A 140-cycle high pulse mid-frame. Required: error set, no frame_done, value[31:24] unchanged. Decoding recovers after a 1350-cycle gap.
6. rst_n pulsed low during bit 12 of a pixel. Required: all outputs 0 immediately; the remainder of that frame produces no valid pulse; the following frame decodes correctly.

Source files
------------

// File: rtl/ws2812_pkg.sv
// ---------------------------------------------------------------------------
// ws2812_pkg
//
// Purpose:
//   Shared WS2812 timing source for the transmitter and the receiver. Pulse
//   timings are kept in nanoseconds and turned into clock cycles by
//   nsToCycles(), so every block derives its thresholds from the same numbers.
//   The package also holds the receiver FSM state encoding and the widths of
//   the receiver counters.
//
// Contents:
//   T_MIN_NS / T_THR_NS / T_HMAX_NS / T_RST_NS  pulse timings in ns
//   CNT_W, BIT_CNT_W, PIX_CNT_W, WORD_W         counter and word widths
//   rxState_t                                   receiver FSM states
//   nsToCycles()                                ns -> clock cycles (truncating)
// ---------------------------------------------------------------------------
package ws2812_pkg;

    // Shortest high-time still accepted as a data bit; anything shorter is a glitch.
    localparam int T_MIN_NS  = 150;
    // High-time at or above this decodes as a 1.
    localparam int T_THR_NS  = 600;
    // High-time at which the line is considered stuck high.
    localparam int T_HMAX_NS = 5000;
    // Low-time that latches the chain and ends a frame.
    localparam int T_RST_NS  = 50000;

    localparam int CNT_W     = 16;
    localparam int BIT_CNT_W = 5;
    localparam int PIX_CNT_W = 8;
    localparam int WORD_W    = 24;

    typedef enum logic [1:0] {
        ST_WAIT_GAP = 2'd0,
        ST_IDLE     = 2'd1,
        ST_HIGH     = 2'd2,
        ST_LOW      = 2'd3
    } rxState_t;

    // Integer truncation matches the transmitter's rounding.
    function automatic int nsToCycles(input int clkMhz, input int ns);
        return (clkMhz * ns) / 1000;
    endfunction

endpackage

// File: rtl/ws2812_rx_phy.sv
// ---------------------------------------------------------------------------
// ws2812_rx_phy
//
// Purpose:
//   Line-side half of the WS2812 receiver. Synchronizes the raw data line,
//   detects edges and measures the high and low times of each pulse. It turns
//   the line into single-cycle events that the framing logic consumes.
//
// Ports:
//   i_clk       system clock
//   i_rst_n     asynchronous active-low reset
//   i_din       raw data line, asynchronous to i_clk
//   o_bit_stb   one-cycle strobe: a well-formed bit was received
//   o_bit_val   value of that bit, valid with o_bit_stb
//   o_glitch    one-cycle strobe: high pulse shorter than T_MIN
//   o_overlong  one-cycle strobe: line held high for T_HMAX, frame aborted
//   o_gap       one-cycle strobe: low time reached T_RST, frame complete
// ---------------------------------------------------------------------------
module ws2812_rx_phy
    import ws2812_pkg::*;
#(
    parameter int CLK_MHZ = 27
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_din,
    output logic o_bit_stb,
    output logic o_bit_val,
    output logic o_glitch,
    output logic o_overlong,
    output logic o_gap
);

    localparam logic [CNT_W-1:0] T_MIN     = CNT_W'(nsToCycles(CLK_MHZ, T_MIN_NS));
    localparam logic [CNT_W-1:0] T_THR     = CNT_W'(nsToCycles(CLK_MHZ, T_THR_NS));
    localparam logic [CNT_W-1:0] T_HMAX    = CNT_W'(nsToCycles(CLK_MHZ, T_HMAX_NS));
    localparam logic [CNT_W-1:0] T_RST     = CNT_W'(nsToCycles(CLK_MHZ, T_RST_NS));
    localparam logic [CNT_W-1:0] T_RST_M1  = T_RST - CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync3;
    rxState_t         r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bitStb;
    logic             r_bitVal;
    logic             r_glitch;
    logic             r_overlong;
    logic             r_gap;

    logic             w_rise;
    logic             w_fall;
    rxState_t         w_stateNext;
    logic [CNT_W-1:0] w_cntNext;
    logic             w_bitStbNext;
    logic             w_bitValNext;
    logic             w_glitchNext;
    logic             w_overlongNext;
    logic             w_gapNext;

    // r_sync3 is the previous synchronized sample, used only for edge detection.
    assign w_rise = r_sync2 & ~r_sync3;
    assign w_fall = ~r_sync2 & r_sync3;

    // State, pulse counter and registered strobes. The strobes are registered
    // so the framing logic sees clean single-cycle events.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_sync3    <= 1'b0;
            r_state    <= ST_WAIT_GAP;
            r_cnt      <= '0;
            r_bitStb   <= 1'b0;
            r_bitVal   <= 1'b0;
            r_glitch   <= 1'b0;
            r_overlong <= 1'b0;
            r_gap      <= 1'b0;
        end else begin
            r_sync1    <= i_din;
            r_sync2    <= r_sync1;
            r_sync3    <= r_sync2;
            r_state    <= w_stateNext;
            r_cnt      <= w_cntNext;
            r_bitStb   <= w_bitStbNext;
            r_bitVal   <= w_bitValNext;
            r_glitch   <= w_glitchNext;
            r_overlong <= w_overlongNext;
            r_gap      <= w_gapNext;
        end
    end

    // Next-state logic. r_cnt holds the number of cycles already spent at the
    // current level, so on the first cycle of the opposite level it equals the
    // full length of the pulse that just ended.
    always_comb begin
        w_stateNext    = r_state;
        w_cntNext      = r_cnt;
        w_bitStbNext   = 1'b0;
        w_bitValNext   = 1'b0;
        w_glitchNext   = 1'b0;
        w_overlongNext = 1'b0;
        w_gapNext      = 1'b0;

        unique case (r_state)
            // Wait for a full reset gap before trusting the line; any high
            // sample means we may be in the middle of someone else's frame.
            ST_WAIT_GAP: begin
                if (r_sync2) begin
                    w_cntNext = '0;
                end else if (r_cnt == T_RST_M1) begin
                    w_stateNext = ST_IDLE;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext = r_cnt + CNT_ONE;
                end
            end

            ST_IDLE: begin
                if (w_rise) begin
                    w_stateNext = ST_HIGH;
                    w_cntNext   = CNT_ONE;
                end
            end

            // The overlong check comes first so a pulse that reaches T_HMAX is
            // never classified as a bit, even if it falls on that same cycle.
            ST_HIGH: begin
                if (r_cnt >= T_HMAX) begin
                    w_overlongNext = 1'b1;
                    w_stateNext    = ST_WAIT_GAP;
                    w_cntNext      = '0;
                end else if (w_fall) begin
                    if (r_cnt < T_MIN) begin
                        w_glitchNext = 1'b1;
                    end else begin
                        w_bitStbNext = 1'b1;
                        w_bitValNext = (r_cnt >= T_THR);
                    end
                    w_stateNext = ST_LOW;
                    w_cntNext   = CNT_ONE;
                end else begin
                    w_cntNext = r_cnt + CNT_ONE;
                end
            end

            ST_LOW: begin
                if (w_rise) begin
                    w_stateNext = ST_HIGH;
                    w_cntNext   = CNT_ONE;
                end else if (r_cnt == T_RST) begin
                    w_gapNext   = 1'b1;
                    w_stateNext = ST_IDLE;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext = r_cnt + CNT_ONE;
                end
            end

            default: begin
                w_stateNext = ST_WAIT_GAP;
                w_cntNext   = '0;
            end
        endcase
    end

    assign o_bit_stb  = r_bitStb;
    assign o_bit_val  = r_bitVal;
    assign o_glitch   = r_glitch;
    assign o_overlong = r_overlong;
    assign o_gap      = r_gap;

endmodule

// File: rtl/vin_ws2812_rx.sv
// ---------------------------------------------------------------------------
// vin_ws2812_rx
//
// Purpose:
//   WS2812 stream decoder input plugin. Assembles decoded bits into 24-bit GRB
//   pixel words, captures the word of one selected pixel position per frame
//   and reports how many complete pixels each finished frame carried.
//
// Parameters:
//   CLK_MHZ    system clock in MHz; all pulse thresholds derive from it
//   LED_INDEX  pixel position (0..255) whose GRB word is captured
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset; clears all state and outputs
//   din         raw WS2812 data line, asynchronous to clk
//   value       [23:0] last captured GRB word,
//               [31:24] pixel count of the last completed frame (saturating)
//   valid       one-cycle pulse when value[23:0] updates
//   frame_done  one-cycle pulse when a reset gap ends a frame
//   error       sticky malformed-pulse flag, cleared by rst_n or frame_done
// ---------------------------------------------------------------------------
module vin_ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int CLK_MHZ   = 27,
    parameter int LED_INDEX = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    output logic [31:0] value,
    output logic        valid,
    output logic        frame_done,
    output logic        error
);

    localparam logic [PIX_CNT_W-1:0] LED_IDX  = PIX_CNT_W'(LED_INDEX);
    localparam logic [PIX_CNT_W-1:0] PIX_MAX  = '1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WORD_W - 1);

    logic                 w_bitStb;
    logic                 w_bitVal;
    logic                 w_glitch;
    logic                 w_overlong;
    logic                 w_gap;

    // Only the first 23 bits of a pixel need storing; the 24th bit is merged
    // combinationally so the word is available on the strobe cycle itself.
    logic [WORD_W-2:0]    r_shift;
    logic [BIT_CNT_W-1:0] r_bitCnt;
    logic [PIX_CNT_W-1:0] r_pixCnt;
    logic [WORD_W-1:0]    r_word;
    logic [PIX_CNT_W-1:0] r_frameCnt;
    logic                 r_valid;
    logic                 r_frameDone;
    logic                 r_error;

    logic [WORD_W-1:0]    w_wordNext;
    logic                 w_lastBit;
    logic                 w_capture;

    ws2812_rx_phy #(
        .CLK_MHZ    (CLK_MHZ)
    ) u_phy (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_din      (din),
        .o_bit_stb  (w_bitStb),
        .o_bit_val  (w_bitVal),
        .o_glitch   (w_glitch),
        .o_overlong (w_overlong),
        .o_gap      (w_gap)
    );

    assign w_wordNext = {r_shift, w_bitVal};
    assign w_lastBit  = (r_bitCnt == LAST_BIT);
    assign w_capture  = w_bitStb && w_lastBit && (r_pixCnt == LED_IDX);

    // Bit and pixel bookkeeping. Counters restart whenever a frame ends or is
    // aborted, which is exactly when the line returns to the idle state, so
    // the next rising edge always starts from a clean pixel 0, bit 0. A
    // partial pixel left over at a gap simply gets dropped here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift  <= '0;
            r_bitCnt <= '0;
            r_pixCnt <= '0;
        end else if (w_gap || w_overlong) begin
            r_bitCnt <= '0;
            r_pixCnt <= '0;
        end else if (w_bitStb) begin
            r_shift <= w_wordNext[WORD_W-2:0];
            if (w_lastBit) begin
                r_bitCnt <= '0;
                if (r_pixCnt != PIX_MAX) begin
                    r_pixCnt <= r_pixCnt + PIX_CNT_W'(1);
                end
            end else begin
                r_bitCnt <= r_bitCnt + BIT_CNT_W'(1);
            end
        end
    end

    // Output capture. The selected pixel's word and the frame's pixel count
    // are held until overwritten; valid and frame_done pulse for one cycle.
    // An aborted frame never produces w_gap, so its count is never published.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word      <= '0;
            r_frameCnt  <= '0;
            r_valid     <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_frameDone <= 1'b0;
            if (w_capture) begin
                r_word  <= w_wordNext;
                r_valid <= 1'b1;
            end
            if (w_gap) begin
                r_frameCnt  <= r_pixCnt;
                r_frameDone <= 1'b1;
            end
        end
    end

    // Sticky error flag: any malformed pulse sets it and it survives until a
    // frame completes cleanly, so software polling once per frame sees it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_error <= 1'b0;
        end else if (w_gap) begin
            r_error <= 1'b0;
        end else if (w_glitch || w_overlong) begin
            r_error <= 1'b1;
        end
    end

    assign value      = {r_frameCnt, r_word};
    assign valid      = r_valid;
    assign frame_done = r_frameDone;
    assign error      = r_error;

endmodule
